write_back_arbiter: RTL and testbench

Collects results from several functional units and writes at most one of them per cycle into the register file. Each accepted result is addressed to one architectural register. The block drives that register's cell with a one-hot write-back strobe and a shared data bus, and the cell then clears its write-reserve bit. The block sits directly upstream of the register cells: functional units feed it, and the cells consume its write strobes.

---
 rtl/write_back_arbiter_pkg.sv | 13 +
 rtl/write_back_arbiter_rr_arbiter.sv | 32 +++
 rtl/write_back_arbiter.sv | 105 ++++++++++
 tb/tb_write_back_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/write_back_arbiter_pkg.sv
// Shared register-file parameters and the write-back payload carried by each result buffer.
package register_params;

  localparam int unsigned OPERAND_WIDTH   = 32;
  localparam int unsigned REG_COUNT       = 32;
  localparam int unsigned REG_INDEX_WIDTH = $clog2(REG_COUNT);

  typedef struct packed {
    logic [REG_INDEX_WIDTH-1:0] index;
    logic [OPERAND_WIDTH-1:0]   data;
  } wb_entry_t;

endpackage

// File: rtl/write_back_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after pointer, wrapping at N.
module rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = $clog2(N)
) (
  input  logic [N-1:0]  request,
  input  logic [PW-1:0] pointer,
  output logic [N-1:0]  grant,
  output logic          grant_valid
);

  always_comb begin
    logic [PW:0]   sum;
    logic [PW-1:0] idx;
    grant       = '0;
    grant_valid = 1'b0;
    sum         = '0;
    idx         = '0;
    for (int unsigned k = 0; k < N; k++) begin
      sum = {1'b0, pointer} + (PW+1)'(k);
      if (sum >= (PW+1)'(N)) begin
        sum = sum - (PW+1)'(N);
      end
      idx = sum[PW-1:0];
      if (!grant_valid && request[idx]) begin
        grant[idx]  = 1'b1;
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/write_back_arbiter.sv
// Buffers one result per functional unit and writes at most one per cycle into the register cells.
// Optional macro WB_ZERO_DROP_EN: results for register 0 drain without emitting a strobe.
module write_back_arbiter
  import register_params::*;
#(
  parameter int unsigned NUM_SOURCES = 4
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic [NUM_SOURCES-1:0]                          src_valid,
  output logic [NUM_SOURCES-1:0]                          src_ready,
  input  logic [NUM_SOURCES-1:0][REG_INDEX_WIDTH-1:0]     src_reg_index,
  input  logic [NUM_SOURCES-1:0][OPERAND_WIDTH-1:0]       src_data,
  input  logic [REG_COUNT-1:0]                            reserve_onehot,
  output logic [REG_COUNT-1:0]                            write_back_onehot,
  output logic [OPERAND_WIDTH-1:0]                        write_back_data,
  output logic [REG_INDEX_WIDTH-1:0]                      write_back_index
);

  localparam int unsigned PTR_WIDTH = $clog2(NUM_SOURCES);

  logic [NUM_SOURCES-1:0] full;
  logic [NUM_SOURCES-1:0] eligible;
  logic [NUM_SOURCES-1:0] grant;
  logic                   grant_valid;
  logic                   emit;
  logic [PTR_WIDTH-1:0]   rr_ptr;
  logic [PTR_WIDTH-1:0]   grant_idx;
  logic [PTR_WIDTH-1:0]   rr_ptr_next;
  wb_entry_t              entry [NUM_SOURCES];
  wb_entry_t              grant_entry;

  // The cell favours reserve over write-back, so a reserved destination is held back.
  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < NUM_SOURCES; i++) begin
      eligible[i] = full[i] && !reserve_onehot[entry[i].index];
    end
  end

  rr_arbiter #(
    .N  (NUM_SOURCES),
    .PW (PTR_WIDTH)
  ) u_rr_arbiter (
    .request     (eligible),
    .pointer     (rr_ptr),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  always_comb begin
    grant_idx   = '0;
    grant_entry = '0;
    for (int unsigned i = 0; i < NUM_SOURCES; i++) begin
      if (grant[i]) begin
        grant_idx   = PTR_WIDTH'(i);
        grant_entry = entry[i];
      end
    end
  end

  assign rr_ptr_next = (grant_idx == PTR_WIDTH'(NUM_SOURCES - 1)) ? '0
                                                                  : grant_idx + PTR_WIDTH'(1);

`ifdef WB_ZERO_DROP_EN
  assign emit = grant_valid && (grant_entry.index != '0);
`else
  assign emit = grant_valid;
`endif

  always_comb begin
    write_back_onehot = '0;
    write_back_data   = '0;
    write_back_index  = '0;
    if (emit) begin
      write_back_onehot = REG_COUNT'(1) << grant_entry.index;
      write_back_data   = grant_entry.data;
      write_back_index  = grant_entry.index;
    end
  end

  // A buffer being drained this cycle can take a new result at the same edge.
  assign src_ready = {NUM_SOURCES{!rst}} & (~full | grant);

  always_ff @(posedge clk) begin
    if (rst) begin
      full   <= '0;
      rr_ptr <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_SOURCES; i++) begin
        if (src_valid[i] && src_ready[i]) begin
          full[i]        <= 1'b1;
          entry[i].index <= src_reg_index[i];
          entry[i].data  <= src_data[i];
        end else if (grant[i]) begin
          full[i] <= 1'b0;
        end
      end
      if (grant_valid) begin
        rr_ptr <= rr_ptr_next;
      end
    end
  end

endmodule

// File: tb/tb_write_back_arbiter.sv
// Directed bench for write_back_arbiter with a queue-style reference model checked every cycle.
module tb_write_back_arbiter;
  import register_params::*;

  localparam int N = 4;

  logic                                    clk = 1'b0;
  logic                                    rst = 1'b1;
  logic [N-1:0]                            src_valid = '0;
  logic [N-1:0]                            src_ready;
  logic [N-1:0][REG_INDEX_WIDTH-1:0]       src_reg_index = '0;
  logic [N-1:0][OPERAND_WIDTH-1:0]         src_data = '0;
  logic [REG_COUNT-1:0]                    reserve_onehot = '0;
  logic [REG_COUNT-1:0]                    write_back_onehot;
  logic [OPERAND_WIDTH-1:0]                write_back_data;
  logic [REG_INDEX_WIDTH-1:0]              write_back_index;

  always #5 clk = ~clk;

  write_back_arbiter #(.NUM_SOURCES(N)) dut (
    .clk               (clk),
    .rst               (rst),
    .src_valid         (src_valid),
    .src_ready         (src_ready),
    .src_reg_index     (src_reg_index),
    .src_data          (src_data),
    .reserve_onehot    (reserve_onehot),
    .write_back_onehot (write_back_onehot),
    .write_back_data   (write_back_data),
    .write_back_index  (write_back_index)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one pending result per source plus the next source to search from.
  bit                         mfull [N];
  logic [REG_INDEX_WIDTH-1:0] midx  [N];
  logic [OPERAND_WIDTH-1:0]   mdata [N];
  int                         mptr = 0;
  bit                         model_live = 1'b0;

  function automatic int model_grant();
    for (int k = 0; k < N; k++) begin
      int s;
      s = (mptr + k) % N;
      if (mfull[s] && !reserve_onehot[midx[s]]) return s;
    end
    return -1;
  endfunction

  always @(posedge clk) begin : model_update
    int g;
    g = model_grant();
    if (rst) begin
      for (int i = 0; i < N; i++) mfull[i] = 1'b0;
      mptr = 0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (src_valid[i] && (!mfull[i] || g == i)) begin
          bit clash;
          clash = 1'b0;
          for (int j = 0; j < N; j++) begin
            if (j != i && j != g && mfull[j] && midx[j] == src_reg_index[i]) clash = 1'b1;
          end
          if (model_live) check("one_inflight_per_reg", 64'(clash), 64'd0);
          mfull[i] = 1'b1;
          midx[i]  = src_reg_index[i];
          mdata[i] = src_data[i];
        end else if (g == i) begin
          mfull[i] = 1'b0;
        end
      end
      if (g >= 0) mptr = (g + 1) % N;
    end
  end

  always @(negedge clk) begin : compare
    int                         g;
    bit                         drop;
    logic [REG_COUNT-1:0]       eo;
    logic [OPERAND_WIDTH-1:0]   ed;
    logic [REG_INDEX_WIDTH-1:0] ei;
    logic [N-1:0]               er;
    if (model_live) begin
      g  = model_grant();
      eo = '0;
      ed = '0;
      ei = '0;
      er = '0;
      if (rst) begin
        check("cmp_ready_in_reset", 64'(src_ready), 64'd0);
      end else begin
        for (int i = 0; i < N; i++) er[i] = !mfull[i] || (g == i);
        if (g >= 0) begin
`ifdef WB_ZERO_DROP_EN
          drop = (midx[g] == '0);
`else
          drop = 1'b0;
`endif
          if (!drop) begin
            eo[midx[g]] = 1'b1;
            ed = mdata[g];
            ei = midx[g];
          end
        end
        check("cmp_onehot", 64'(write_back_onehot), 64'(eo));
        check("cmp_data",   64'(write_back_data),   64'(ed));
        check("cmp_index",  64'(write_back_index),  64'(ei));
        check("cmp_ready",  64'(src_ready),         64'(er));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    src_valid = '0;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic offer(input int s, input int idx, input logic [OPERAND_WIDTH-1:0] data);
    src_valid[s]     = 1'b1;
    src_reg_index[s] = REG_INDEX_WIDTH'(idx);
    src_data[s]      = data;
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    src_valid      = '0;
    reserve_onehot = '0;
    tick();
    settle();
    check("reset_ready_low", 64'(src_ready), 64'd0);
    rst = 1'b0;
    settle();
    check("reset_onehot_zero", 64'(write_back_onehot), 64'd0);
    check("reset_ready_high",  64'(src_ready),         64'hF);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    model_live = 1'b1;

    // Single write after reset
    do_reset();
    offer(0, 5, 32'hDEAD);
    settle();
    check("t1_ready0_pre", 64'(src_ready[0]), 64'd1);
    tick(); settle();
    check("t1_onehot", 64'(write_back_onehot), 64'h20);
    check("t1_data",   64'(write_back_data),   64'hDEAD);
    check("t1_index",  64'(write_back_index),  64'd5);
    check("t1_ready0", 64'(src_ready[0]),      64'd1);
    tick(); settle();
    check("t1_idle", 64'(write_back_onehot), 64'd0);

    // Round-robin across four simultaneous results
    do_reset();
    for (int i = 0; i < N; i++) offer(i, i + 1, 32'h100 + 32'(i));
    tick(); settle();
    check("t2_grant0", 64'(write_back_onehot), 64'h2);
    tick(); settle();
    check("t2_grant1", 64'(write_back_onehot), 64'h4);
    check("t2_data1",  64'(write_back_data),   64'h101);
    tick(); settle();
    check("t2_grant2", 64'(write_back_onehot), 64'h8);
    tick(); settle();
    check("t2_grant3", 64'(write_back_onehot), 64'h10);
    tick(); settle();
    check("t2_idle", 64'(write_back_onehot), 64'd0);
    offer(1, 6, 32'h61);
    offer(0, 7, 32'h70);
    tick(); settle();
    check("t2_ptr_wrapped", 64'(write_back_onehot), 64'h80);
    tick(); settle();
    check("t2_ptr_next", 64'(write_back_onehot), 64'h40);
    tick();

    // Reserve conflict holds source 1 while source 2 proceeds
    do_reset();
    reserve_onehot = 32'h80;
    offer(1, 7, 32'h77);
    offer(2, 9, 32'h99);
    tick(); settle();
    check("t3_other_granted", 64'(write_back_onehot), 64'h200);
    check("t3_other_data",    64'(write_back_data),   64'h99);
    check("t3_ready1_a",      64'(src_ready[1]),      64'd0);
    tick(); settle();
    check("t3_withheld_b", 64'(write_back_onehot), 64'd0);
    check("t3_ready1_b",   64'(src_ready[1]),      64'd0);
    tick(); settle();
    check("t3_withheld_c", 64'(write_back_onehot), 64'd0);
    check("t3_ready1_c",   64'(src_ready[1]),      64'd0);
    tick();
    reserve_onehot = '0;
    settle();
    check("t3_released",      64'(write_back_onehot), 64'h80);
    check("t3_released_data", 64'(write_back_data),   64'h77);
    check("t3_ready1_d",      64'(src_ready[1]),      64'd1);
    tick(); settle();
    check("t3_idle", 64'(write_back_onehot), 64'd0);

    // Back-to-back refill of source 0
    do_reset();
    offer(0, 10, 32'h1000);
    for (int k = 0; k < 6; k++) begin
      tick();
      if (k < 5) offer(0, 11 + k, 32'h1000 + 32'(k + 1));
      settle();
      check("t4_onehot", 64'(write_back_onehot), 64'(32'd1 << (10 + k)));
      check("t4_data",   64'(write_back_data),   64'(32'h1000 + 32'(k)));
      check("t4_ready0", 64'(src_ready[0]),      64'd1);
    end
    tick(); settle();
    check("t4_idle", 64'(write_back_onehot), 64'd0);

    // Reset with three buffers full discards them
    do_reset();
    reserve_onehot = 32'h0070_0000;
    offer(0, 20, 32'hA0);
    offer(1, 21, 32'hA1);
    offer(2, 22, 32'hA2);
    tick();
    rst = 1'b1;
    settle();
    check("t5_ready_in_rst", 64'(src_ready),         64'd0);
    check("t5_none_in_rst",  64'(write_back_onehot), 64'd0);
    tick();
    rst            = 1'b0;
    reserve_onehot = '0;
    settle();
    check("t5_after_onehot", 64'(write_back_onehot), 64'd0);
    check("t5_after_ready",  64'(src_ready),         64'hF);
    for (int k = 0; k < 3; k++) begin
      tick(); settle();
      check("t5_discarded", 64'(write_back_onehot), 64'd0);
    end

    // Register 0 destination, pointer advance from source 3
    do_reset();
    offer(2, 4, 32'h44);
    tick(); settle();
    check("t6_src2", 64'(write_back_onehot), 64'h10);
    offer(3, 0, 32'hFF);
    tick(); settle();
`ifdef WB_ZERO_DROP_EN
    check("t6_zero_onehot", 64'(write_back_onehot), 64'd0);
    check("t6_zero_data",   64'(write_back_data),   64'd0);
`else
    check("t6_zero_onehot", 64'(write_back_onehot), 64'h1);
    check("t6_zero_data",   64'(write_back_data),   64'hFF);
`endif
    check("t6_zero_index", 64'(write_back_index), 64'd0);
    check("t6_ready3",     64'(src_ready[3]),     64'd1);
    tick(); settle();
    check("t6_drained_onehot", 64'(write_back_onehot), 64'd0);
    check("t6_drained_ready3", 64'(src_ready[3]),      64'd1);
    offer(1, 2, 32'h20);
    offer(3, 3, 32'h30);
    tick(); settle();
    check("t6_ptr_at_0", 64'(write_back_onehot), 64'h4);
    tick(); settle();
    check("t6_then_src3", 64'(write_back_onehot), 64'h8);
    tick(); settle();
    check("t6_idle", 64'(write_back_onehot), 64'd0);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
